// File: rtl/vmem_arb_pkg.sv
// Shared types and constants for the vmem port arbiter slice.
package vmem_arb_pkg;

  typedef enum logic {INIT, RUN} state_t;

  typedef logic req_id_t;

  localparam int NUM_REQ    = 2;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Legal read-latency window of the array the arbiter can track.
  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/vmem_rd_tracker.sv
// Read tag pipeline: follows each issued read through the array latency
// and steers the returning odata to the requester that issued it.
module vmem_rd_tracker
  import vmem_arb_pkg::*;
#(
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_vld,
  input  req_id_t                       issue_id,
  input  logic [DW-1:0]                 mem_rdata,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [NUM_REQ-1:0][DW-1:0]    rdata
);

  // Stage k holds the tag of a read issued k cycles ago; stage RD_LAT is the tail.
  logic [RD_LAT:1] vld_pipe;
  logic [RD_LAT:1] id_pipe;

  // Shift tags toward the tail; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= issue_vld;
      id_pipe[1]  <= issue_id;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
    end
  end

  // Tail demux: one response pulse per read, data zeroed when not ours.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rvalid[i] = vld_pipe[RD_LAT] && (id_pipe[RD_LAT] == req_id_t'(i));
    assign rdata[i]  = rvalid[i] ? mem_rdata : '0;
  end

endmodule

// File: rtl/vmem_port_arbiter.sv
// Owns the single vmem array port: clears the array after reset, then
// round-robins two requesters one access per cycle and routes read data back.
module vmem_port_arbiter
  import vmem_arb_pkg::*;
#(
  parameter int              AW       = 4,
  parameter int              DW       = 8,
  parameter int              DEPTH    = 16,
  parameter int              RD_LAT   = 1,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic          r0_wen,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic          r1_wen,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          init_done
);

  if (!(DEPTH == (1 << AW)) || !rd_lat_ok(RD_LAT)) begin : g_bad_param
    $error("vmem_port_arbiter: DEPTH must be 2**AW and RD_LAT within 1..4");
  end

  // One past AW so the clear count can never alias before DEPTH writes.
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  logic [NUM_REQ-1:0]         valid, wen;
  logic [NUM_REQ-1:0][AW-1:0] addr;
  logic [NUM_REQ-1:0][DW-1:0] wdata;

  assign valid = {r1_valid, r0_valid};
  assign wen   = {r1_wen,   r0_wen};
  assign addr  = {r1_addr,  r0_addr};
  assign wdata = {r1_wdata, r0_wdata};

  state_t             state, state_n;
  logic [AW:0]        cnt;
  req_id_t            prio, win;
  logic               any_vld, done_q;
  logic [NUM_REQ-1:0] grant;
  logic               m_ren, m_wen;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_n;
  end

  // Clear address counter, only advances while clearing.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (state == INIT) cnt <= cnt + 1'b1;
  end

  // Round-robin pointer: after a grant the other requester gets preference.
  always_ff @(posedge clk) begin
    if (rst)          prio <= 1'b0;
    else if (any_vld) prio <= ~win;
  end

  // Sticky init-complete flag, set as the FSM enters RUN.
  always_ff @(posedge clk) begin
    if (rst)               done_q <= 1'b0;
    else if (state_n == RUN) done_q <= 1'b1;
  end

  // Next state, grant selection and array drive; all outputs forced low in reset.
  always_comb begin
    state_n = state;
    win     = prio;
    any_vld = 1'b0;
    grant   = '0;
    m_ren   = 1'b0;
    m_wen   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    case (state)
      INIT: begin
        m_wen   = 1'b1;
        m_addr  = cnt[AW-1:0];
        m_wdata = INIT_VAL;
        if (cnt == CNT_LAST) state_n = RUN;
      end
      RUN: begin
        if (valid != '0) begin
          any_vld    = 1'b1;
          win        = (&valid) ? prio : req_id_t'(valid[1]);
          grant[win] = 1'b1;
          m_addr     = addr[win];
          m_wdata    = wdata[win];
          m_wen      = wen[win];
          m_ren      = ~wen[win];
        end
      end
      default: state_n = INIT;
    endcase
    if (rst) begin
      any_vld = 1'b0;
      grant   = '0;
      m_ren   = 1'b0;
      m_wen   = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
    end
  end

  logic [NUM_REQ-1:0]         trk_rvalid;
  logic [NUM_REQ-1:0][DW-1:0] trk_rdata;

  vmem_rd_tracker #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_tracker (
    .clk       (clk),
    .rst       (rst),
    .issue_vld (m_ren),
    .issue_id  (win),
    .mem_rdata (mem_rdata),
    .rvalid    (trk_rvalid),
    .rdata     (trk_rdata)
  );

  assign r0_ready  = grant[0];
  assign r1_ready  = grant[1];
  assign mem_ren   = m_ren;
  assign mem_wen   = m_wen;
  assign mem_addr  = m_addr;
  assign mem_wdata = m_wdata;
  assign init_done = done_q & ~rst;
  assign r0_rvalid = trk_rvalid[0] & ~rst;
  assign r1_rvalid = trk_rvalid[1] & ~rst;
  assign r0_rdata  = rst ? '0 : trk_rdata[0];
  assign r1_rdata  = rst ? '0 : trk_rdata[1];

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Bench for vmem_port_arbiter: behavioural 16x8 array with RD_LAT latency,
// directed scenarios plus randomized traffic against a transaction-level model.
module tb_vmem_port_arbiter;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r0_valid, r0_ready, r0_wen, r0_rvalid;
  logic [3:0] r0_addr;
  logic [7:0] r0_wdata, r0_rdata;
  logic       r1_valid, r1_ready, r1_wen, r1_rvalid;
  logic [3:0] r1_addr;
  logic [7:0] r1_wdata, r1_rdata;
  logic       mem_ren, mem_wen, init_done;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  vmem_port_arbiter #(
    .AW(4), .DW(8), .DEPTH(16), .RD_LAT(LAT), .INIT_VAL(8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_wen(r0_wen), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_wen(r1_wen), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .init_done(init_done)
  );

  // Behavioural array: registered read, then LAT-1 extra delay stages.
  logic [7:0] arr [16];
  logic [7:0] rd_q [1:LAT];
  always @(posedge clk) begin
    if (mem_wen) arr[mem_addr] <= mem_wdata;
    rd_q[1] <= mem_ren ? arr[mem_addr] : 8'h5C;
    for (int k = 2; k <= LAT; k++) rd_q[k] <= rd_q[k-1];
  end
  assign mem_rdata = rd_q[LAT];

  logic [16:0] act_bus;
  logic [17:0] act_rsp;
  assign act_bus = {r1_ready, r0_ready, mem_wen, mem_ren, mem_addr, mem_wdata, init_done};
  assign act_rsp = {r1_rvalid, r1_rdata, r0_rvalid, r0_rdata};

  int total = 0;
  int bad   = 0;

  // ---------------- transaction-level reference model ----------------
  typedef struct { int id; logic [7:0] data; int due; } rsp_t;
  rsp_t       rq[$];
  logic [7:0] ref_mem [16];
  bit         m_init = 1'b1, m_done = 1'b0;
  int         m_cnt = 0, m_prio = 0, cyc = 0, g = -1;
  bit         m_w;
  logic [3:0] m_a;
  logic [7:0] m_d;
  logic [16:0] e_bus;
  logic [17:0] e_rsp;

  // Expected outputs for the current cycle given current inputs.
  task automatic model_eval();
    e_bus = '0;
    e_rsp = '0;
    g = -1;
    m_w = 1'b0; m_a = '0; m_d = '0;
    if (!rst) begin
      if (m_init) begin
        e_bus = {2'b00, 1'b1, 1'b0, 4'(m_cnt), 8'h00, 1'b0};
      end else begin
        if (r0_valid && r1_valid) g = m_prio;
        else if (r0_valid)        g = 0;
        else if (r1_valid)        g = 1;
        if (g == 0) {m_w, m_a, m_d} = {r0_wen, r0_addr, r0_wdata};
        if (g == 1) {m_w, m_a, m_d} = {r1_wen, r1_addr, r1_wdata};
        if (g >= 0) e_bus = {1'(g == 1), 1'(g == 0), m_w, ~m_w, m_a, m_d, m_done};
        else        e_bus = {16'h0000, m_done};
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        if (rq[0].id == 0) e_rsp[8:0]  = {1'b1, rq[0].data};
        else               e_rsp[17:9] = {1'b1, rq[0].data};
      end
    end
  endtask

  // Commit the effects of the current cycle.
  task automatic model_adv();
    if (rst) begin
      m_init = 1'b1; m_done = 1'b0; m_cnt = 0; m_prio = 0;
      rq.delete();
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (m_init) begin
        ref_mem[m_cnt] = 8'h00;
        m_cnt++;
        if (m_cnt == 16) begin m_init = 1'b0; m_done = 1'b1; end
      end else if (g >= 0) begin
        m_prio = 1 - g;
        if (m_w) ref_mem[m_a] = m_d;
        else     rq.push_back('{g, ref_mem[m_a], cyc + LAT});
      end
    end
    cyc++;
  endtask

  task automatic t_eval();
    @(negedge clk);
    model_eval();
  endtask

  task automatic t_adv();
    model_adv();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t_eval();
      total++;
      if (act_bus !== 17'h0 || act_rsp !== 18'h0) begin
        bad++;
        $display("FAIL reset_outputs bus=%h rsp=%h need 0", act_bus, act_rsp);
      end
      t_adv();
    end
    rst = 1'b0;
  endtask

  task automatic test_init();
    r0_valid = 1'b1; r0_wen = 1'b0; r0_addr = 4'h5;
    for (int i = 0; i < 16; i++) begin
      t_eval();
      total++;
      if (act_bus !== {2'b00, 1'b1, 1'b0, 4'(i), 8'h00, 1'b0}) begin
        bad++;
        $display("FAIL init_write[%0d] bus=%h need=%h", i, act_bus,
                 {2'b00, 1'b1, 1'b0, 4'(i), 8'h00, 1'b0});
      end
      t_adv();
    end
    t_eval();
    total++;
    if (init_done !== 1'b1 || r0_ready !== 1'b1 || r1_ready !== 1'b0 ||
        mem_ren !== 1'b1 || mem_addr !== 4'h5) begin
      bad++;
      $display("FAIL first_run done=%b r0_ready=%b r1_ready=%b ren=%b addr=%h need 1,1,0,1,5",
               init_done, r0_ready, r1_ready, mem_ren, mem_addr);
    end
    t_adv();
    r0_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      t_eval();
      total++;
      if (act_rsp !== ((k == LAT) ? {9'h000, 1'b1, 8'h00} : 18'h0)) begin
        bad++;
        $display("FAIL init_clear_read k=%0d rsp=%h", k, act_rsp);
      end
      t_adv();
    end
  endtask

  task automatic test_wr_rd();
    r0_valid = 1'b1; r0_wen = 1'b1; r0_addr = 4'h3; r0_wdata = 8'hA5;
    t_eval();
    total++;
    if (r0_ready !== 1'b1 || mem_wen !== 1'b1 || mem_ren !== 1'b0 ||
        mem_addr !== 4'h3 || mem_wdata !== 8'hA5) begin
      bad++;
      $display("FAIL wr_issue ready=%b wen=%b ren=%b addr=%h wdata=%h need 1,1,0,3,a5",
               r0_ready, mem_wen, mem_ren, mem_addr, mem_wdata);
    end
    t_adv();
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_wen = 1'b0; r1_addr = 4'h3;
    t_eval();
    total++;
    if (r1_ready !== 1'b1 || r0_ready !== 1'b0 || mem_ren !== 1'b1 || mem_addr !== 4'h3) begin
      bad++;
      $display("FAIL rd_issue r1_ready=%b r0_ready=%b ren=%b addr=%h need 1,0,1,3",
               r1_ready, r0_ready, mem_ren, mem_addr);
    end
    t_adv();
    r1_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      t_eval();
      total++;
      if (act_rsp !== ((k == LAT) ? {1'b1, 8'hA5, 9'h000} : 18'h0)) begin
        bad++;
        $display("FAIL raw_read k=%0d rsp=%h need=%h", k, act_rsp,
                 (k == LAT) ? {1'b1, 8'hA5, 9'h000} : 18'h0);
      end
      t_adv();
    end
  endtask

  task automatic test_alternate();
    r0_valid = 1'b1; r0_wen = 1'b1; r0_addr = 4'h1; r0_wdata = 8'h11;
    t_eval(); t_adv();
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_wen = 1'b1; r1_addr = 4'h2; r1_wdata = 8'h22;
    t_eval(); t_adv();
    r0_valid = 1'b1; r0_wen = 1'b0;
    r1_wen = 1'b0;
    for (int t = 0; t < 6 + LAT; t++) begin
      t_eval();
      if (t < 6) begin
        total++;
        if (r0_ready !== 1'((t % 2) == 0) || r1_ready !== 1'((t % 2) == 1) ||
            mem_ren !== 1'b1 || mem_addr !== (((t % 2) == 0) ? 4'h1 : 4'h2)) begin
          bad++;
          $display("FAIL alt_grant t=%0d r0_ready=%b r1_ready=%b ren=%b addr=%h",
                   t, r0_ready, r1_ready, mem_ren, mem_addr);
        end
      end
      if (t >= LAT) begin
        total++;
        if (act_rsp !== ((((t - LAT) % 2) == 0) ? {9'h000, 1'b1, 8'h11}
                                               : {1'b1, 8'h22, 9'h000})) begin
          bad++;
          $display("FAIL alt_resp t=%0d rsp=%h", t, act_rsp);
        end
      end
      t_adv();
      if (t == 5) begin r0_valid = 1'b0; r1_valid = 1'b0; end
    end
  endtask

  task automatic test_unwritten();
    r1_valid = 1'b1; r1_wen = 1'b0; r1_addr = 4'hF;
    t_eval();
    total++;
    if (r1_ready !== 1'b1 || mem_addr !== 4'hF) begin
      bad++;
      $display("FAIL unwritten_issue ready=%b addr=%h need 1,f", r1_ready, mem_addr);
    end
    t_adv();
    r1_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      t_eval();
      if (k == LAT) begin
        total++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== 8'h00 || r0_rvalid !== 1'b0) begin
          bad++;
          $display("FAIL unwritten_read rvalid=%b rdata=%h r0_rvalid=%b need 1,00,0",
                   r1_rvalid, r1_rdata, r0_rvalid);
        end
      end
      t_adv();
    end
  endtask

  task automatic test_random(input int n);
    int gg;
    for (int c = 0; c < n; c++) begin
      t_eval();
      total++;
      if (act_bus !== e_bus) begin
        bad++;
        $display("FAIL rand_bus cyc=%0d got=%h need=%h", cyc, act_bus, e_bus);
      end
      total++;
      if (act_rsp !== e_rsp) begin
        bad++;
        $display("FAIL rand_rsp cyc=%0d got=%h need=%h", cyc, act_rsp, e_rsp);
      end
      gg = g;
      t_adv();
      if (!r0_valid || gg == 0) begin
        r0_valid = ($urandom_range(0, 3) != 0);
        r0_wen   = ($urandom_range(0, 2) == 0);
        r0_addr  = 4'($urandom_range(0, 7));
        r0_wdata = 8'($urandom);
      end
      if (!r1_valid || gg == 1) begin
        r1_valid = ($urandom_range(0, 3) != 0);
        r1_wen   = ($urandom_range(0, 2) == 0);
        r1_addr  = 4'($urandom_range(0, 7));
        r1_wdata = 8'($urandom);
      end
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    r0_valid = 1'b1; r0_wen = 1'b0; r0_addr = 4'h1;
    t_eval();
    total++;
    if (r0_ready !== 1'b1 || mem_ren !== 1'b1) begin
      bad++;
      $display("FAIL mid_issue ready=%b ren=%b need 1,1", r0_ready, mem_ren);
    end
    t_adv();
    r0_valid = 1'b0;
    rst = 1'b1;
    t_eval();
    total++;
    if (act_bus !== 17'h0 || act_rsp !== 18'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs bus=%h rsp=%h need 0", act_bus, act_rsp);
    end
    t_adv();
    rst = 1'b0;
    t_eval();
    total++;
    if (act_rsp !== 18'h0 || init_done !== 1'b0 || mem_wen !== 1'b1 || mem_addr !== 4'h0) begin
      bad++;
      $display("FAIL mid_restart rsp=%h done=%b wen=%b addr=%h need 0,0,1,0",
               act_rsp, init_done, mem_wen, mem_addr);
    end
    t_adv();
    test_random(300);
  endtask

  initial begin
    r0_valid = 1'b0; r0_wen = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b0; r1_wen = 1'b0; r1_addr = '0; r1_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      arr[i]     = 8'($urandom);
      ref_mem[i] = 8'hxx;
    end
    for (int k = 1; k <= LAT; k++) rd_q[k] = 8'h00;
    test_reset();
    test_init();
    test_wr_rd();
    test_alternate();
    test_unwritten();
    test_random(400);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
